// File: rtl/gpr_csr_file_pkg.sv
// Shared constants for the GPR/CSR file: CSR map, csr_op encodings,
// trap cause and mstatus layout.
package gpr_csr_file_pkg;

    typedef enum logic [1:0] {
        CSR_NONE = 2'd0,
        CSR_RW   = 2'd1,
        CSR_RS   = 2'd2,
        CSR_RC   = 2'd3
    } csr_op_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam logic [63:0] MCAUSE_ECALL_M = 64'd11;
    localparam logic [63:0] MSTATUS_RESET  = 64'h0000_000A_0000_1800;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MSTATUS_MPP0 = 11;
    localparam int unsigned MSTATUS_MPP1 = 12;

    function automatic logic csr_is_mapped(input logic [11:0] addr);
        return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
               (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
    endfunction

endpackage

// File: rtl/gpr_csr_file_csr_unit.sv
// Machine-mode CSR bank (mstatus, mtvec, mepc, mcause) with ecall/mret
// trap handling and redirect generation.
module csr_unit
    import gpr_csr_file_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_en,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            ecall,
    input  logic            mret,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] mstatus,
    output logic [XLEN-1:0] mtvec,
    output logic [XLEN-1:0] mepc,
    output logic [XLEN-1:0] mcause
);

    csr_op_e         op;
    logic [XLEN-1:0] csr_wdata;
    logic            csr_we;

    assign op = csr_op_e'(csr_op);

    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_MSTATUS: csr_rdata = mstatus;
            CSR_MTVEC:   csr_rdata = mtvec;
            CSR_MEPC:    csr_rdata = mepc;
            CSR_MCAUSE:  csr_rdata = mcause;
            default:     csr_rdata = '0;
        endcase
    end

    always_comb begin
        csr_wdata = csr_rdata;
        case (op)
            CSR_RW:  csr_wdata = csr_src;
            CSR_RS:  csr_wdata = csr_rdata | csr_src;
            CSR_RC:  csr_wdata = csr_rdata & ~csr_src;
            default: csr_wdata = csr_rdata;
        endcase
    end

    // Trap entry/return owns the CSR bank for that commit; explicit writes are dropped.
    assign csr_we = commit_en && (op != CSR_NONE) && !ecall && !mret &&
                    csr_is_mapped(csr_addr);

    assign redirect_valid = commit_en & (ecall | mret);
    assign redirect_pc    = ecall ? mtvec : mepc;

    always_ff @(posedge clock) begin
        if (reset) begin
            mstatus <= MSTATUS_RESET[XLEN-1:0];
            mtvec   <= '0;
            mepc    <= '0;
            mcause  <= '0;
        end else if (commit_en && ecall) begin
            mepc                  <= commit_pc;
            mcause                <= MCAUSE_ECALL_M[XLEN-1:0];
            mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
            mstatus[MSTATUS_MIE]  <= 1'b0;
            mstatus[MSTATUS_MPP1] <= 1'b1;
            mstatus[MSTATUS_MPP0] <= 1'b1;
        end else if (commit_en && mret) begin
            mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
            mstatus[MSTATUS_MPIE] <= 1'b1;
            mstatus[MSTATUS_MPP1] <= 1'b1;
            mstatus[MSTATUS_MPP0] <= 1'b1;
        end else if (csr_we) begin
            case (csr_addr)
                CSR_MSTATUS: mstatus <= csr_wdata;
                CSR_MTVEC:   mtvec   <= csr_wdata;
                CSR_MEPC:    mepc    <= csr_wdata;
                CSR_MCAUSE:  mcause  <= csr_wdata;
                default:     ;
            endcase
        end
    end

endmodule

// File: rtl/gpr_csr_file.sv
// Integer register file with write-first bypass, machine CSR bank,
// retired-instruction counter and difftest trace outputs.
module gpr_csr_file
    import gpr_csr_file_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            commit_en,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            rd_wen,
    input  logic [4:0]      rd_addr,
    input  logic [XLEN-1:0] rd_wdata,
    input  logic [1:0]      csr_op,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_src,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            ecall,
    input  logic            mret,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] trace_gpr_0,
    output logic [XLEN-1:0] trace_gpr_1,
    output logic [XLEN-1:0] trace_gpr_2,
    output logic [XLEN-1:0] trace_gpr_3,
    output logic [XLEN-1:0] trace_gpr_4,
    output logic [XLEN-1:0] trace_gpr_5,
    output logic [XLEN-1:0] trace_gpr_6,
    output logic [XLEN-1:0] trace_gpr_7,
    output logic [XLEN-1:0] trace_gpr_8,
    output logic [XLEN-1:0] trace_gpr_9,
    output logic [XLEN-1:0] trace_gpr_10,
    output logic [XLEN-1:0] trace_gpr_11,
    output logic [XLEN-1:0] trace_gpr_12,
    output logic [XLEN-1:0] trace_gpr_13,
    output logic [XLEN-1:0] trace_gpr_14,
    output logic [XLEN-1:0] trace_gpr_15,
    output logic [XLEN-1:0] trace_gpr_16,
    output logic [XLEN-1:0] trace_gpr_17,
    output logic [XLEN-1:0] trace_gpr_18,
    output logic [XLEN-1:0] trace_gpr_19,
    output logic [XLEN-1:0] trace_gpr_20,
    output logic [XLEN-1:0] trace_gpr_21,
    output logic [XLEN-1:0] trace_gpr_22,
    output logic [XLEN-1:0] trace_gpr_23,
    output logic [XLEN-1:0] trace_gpr_24,
    output logic [XLEN-1:0] trace_gpr_25,
    output logic [XLEN-1:0] trace_gpr_26,
    output logic [XLEN-1:0] trace_gpr_27,
    output logic [XLEN-1:0] trace_gpr_28,
    output logic [XLEN-1:0] trace_gpr_29,
    output logic [XLEN-1:0] trace_gpr_30,
    output logic [XLEN-1:0] trace_gpr_31,
    output logic [XLEN-1:0] trace_csr_0,
    output logic [XLEN-1:0] trace_csr_1,
    output logic [XLEN-1:0] trace_csr_2,
    output logic [XLEN-1:0] trace_csr_3,
    output logic            trace_valid,
    output logic [XLEN-1:0] trace_pc,
    output logic [63:0]     instret
);

    logic [XLEN-1:0] gpr [32];
    logic            gpr_we;

    assign gpr_we = commit_en && rd_wen && (rd_addr != 5'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                gpr[i] <= '0;
            end
        end else if (gpr_we) begin
            gpr[rd_addr] <= rd_wdata;
        end
    end

    // Reads see the retiring write in the same cycle so WB needs no forwarding path.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != 5'd0) begin
            rs1_data = (gpr_we && (rd_addr == rs1_addr)) ? rd_wdata : gpr[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != 5'd0) begin
            rs2_data = (gpr_we && (rd_addr == rs2_addr)) ? rd_wdata : gpr[rs2_addr];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            trace_valid <= 1'b0;
            trace_pc    <= '0;
            instret     <= '0;
        end else begin
            trace_valid <= commit_en;
            trace_pc    <= commit_pc;
            if (commit_en) begin
                instret <= instret + 64'd1;
            end
        end
    end

    csr_unit #(
        .XLEN (XLEN)
    ) u_csr_unit (
        .clock          (clock),
        .reset          (reset),
        .commit_en      (commit_en),
        .commit_pc      (commit_pc),
        .csr_op         (csr_op),
        .csr_addr       (csr_addr),
        .csr_src        (csr_src),
        .csr_rdata      (csr_rdata),
        .ecall          (ecall),
        .mret           (mret),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mstatus        (trace_csr_0),
        .mtvec          (trace_csr_1),
        .mepc           (trace_csr_2),
        .mcause         (trace_csr_3)
    );

    assign trace_gpr_0  = gpr[0];
    assign trace_gpr_1  = gpr[1];
    assign trace_gpr_2  = gpr[2];
    assign trace_gpr_3  = gpr[3];
    assign trace_gpr_4  = gpr[4];
    assign trace_gpr_5  = gpr[5];
    assign trace_gpr_6  = gpr[6];
    assign trace_gpr_7  = gpr[7];
    assign trace_gpr_8  = gpr[8];
    assign trace_gpr_9  = gpr[9];
    assign trace_gpr_10 = gpr[10];
    assign trace_gpr_11 = gpr[11];
    assign trace_gpr_12 = gpr[12];
    assign trace_gpr_13 = gpr[13];
    assign trace_gpr_14 = gpr[14];
    assign trace_gpr_15 = gpr[15];
    assign trace_gpr_16 = gpr[16];
    assign trace_gpr_17 = gpr[17];
    assign trace_gpr_18 = gpr[18];
    assign trace_gpr_19 = gpr[19];
    assign trace_gpr_20 = gpr[20];
    assign trace_gpr_21 = gpr[21];
    assign trace_gpr_22 = gpr[22];
    assign trace_gpr_23 = gpr[23];
    assign trace_gpr_24 = gpr[24];
    assign trace_gpr_25 = gpr[25];
    assign trace_gpr_26 = gpr[26];
    assign trace_gpr_27 = gpr[27];
    assign trace_gpr_28 = gpr[28];
    assign trace_gpr_29 = gpr[29];
    assign trace_gpr_30 = gpr[30];
    assign trace_gpr_31 = gpr[31];

endmodule
